// File: rtl/pipelined_addsub.sv
// Pipelined N-bit adder/subtractor: one SEG_W-bit carry segment per stage,
// valid/ready flow control on both ends, signed-overflow flag.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   input handshake (in_ready = ~out_valid | out_ready)
//   a, b, c_in, sub      operands; sub=1 computes a-b-c_in
//   out_valid, out_ready output handshake
//   sum, c_out, ovf      result, raw carry out, signed overflow
module pipelined_addsub #(
    parameter int N     = 32,
    parameter int SEG_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         ovf
);

    localparam int STAGES = N / SEG_W;

    logic         adv;
    logic [N-1:0] bb;
    logic         cin0;

    assign bb       = sub ? ~b : b;
    assign cin0     = sub ? ~c_in : c_in;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Stage k consumes the low segment of the operand bits it receives,
    // forwards the remaining upper bits and appends its result segment
    // above the lower result bits it received.
    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int LO = k * SEG_W;
        localparam int UW = N - LO;
        localparam int SW = LO + SEG_W;

        logic          v_d;
        logic          c_d;
        logic [UW-1:0] a_d;
        logic [UW-1:0] b_d;
        logic [SEG_W:0] seg;
        logic [SW-1:0] s_n;
        logic          v_q;
        logic          c_q;
        logic [SW-1:0] s_q;

        if (k == 0) begin : src
            assign v_d = in_valid;
            assign c_d = cin0;
            assign a_d = a;
            assign b_d = bb;
            assign s_n = seg[SEG_W-1:0];
        end else begin : src
            assign v_d = stg[k-1].v_q;
            assign c_d = stg[k-1].c_q;
            assign a_d = stg[k-1].skew.a_q;
            assign b_d = stg[k-1].skew.b_q;
            assign s_n = {seg[SEG_W-1:0], stg[k-1].s_q};
        end

        assign seg = {1'b0, a_d[SEG_W-1:0]}
                   + {1'b0, b_d[SEG_W-1:0]}
                   + {{SEG_W{1'b0}}, c_d};

        // Bubbles carry all-zero data so an idle output reads as zero.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_d;
                c_q <= v_d & seg[SEG_W];
                s_q <= v_d ? s_n : '0;
            end
        end

        if (k < STAGES - 1) begin : skew
            logic [UW-SEG_W-1:0] a_q;
            logic [UW-SEG_W-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= v_d ? a_d[UW-1:SEG_W] : '0;
                    b_q <= v_d ? b_d[UW-1:SEG_W] : '0;
                end
            end
        end else begin : fin
            logic ovf_d;
            logic ovf_q;

            // Operand sign bits arrive with the top segment.
            assign ovf_d = (a_d[UW-1] == b_d[UW-1])
                        && (s_n[SW-1] != a_d[UW-1]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= v_d & ovf_d;
                end
            end
        end
    end

    assign out_valid = stg[STAGES-1].v_q;
    assign sum       = stg[STAGES-1].s_q;
    assign c_out     = stg[STAGES-1].c_q;
    assign ovf       = stg[STAGES-1].fin.ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed self-checking bench for pipelined_addsub (N=32, SEG_W=8).
// Immediate assertions at each comparison point.
module tb_pipelined_addsub;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         c_out;
    logic         ovf;

    int n_cmp = 0;
    int n_err = 0;

    logic [33:0] exp_q[$];
    logic [65:0] ops[8];
    int          delivered;
    int          first_del;
    int          last_del;
    logic        held;
    logic [33:0] held_val;

    pipelined_addsub #(.N(32), .SEG_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .c_in(c_in),
        .sub(sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .c_out(c_out),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, c_out, sum} from wide signed/unsigned arithmetic.
    function automatic logic [33:0] model(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic ci,
                                          input logic s);
        longint      sx;
        longint      sy;
        longint      r;
        logic [32:0] u;
        logic [31:0] res;
        logic        co;
        logic        ov;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!s) begin
            u   = {1'b0, x} + {1'b0, y} + 33'(ci);
            res = u[31:0];
            co  = u[32];
            r   = sx + sy + longint'(ci);
        end else begin
            res = x - y - 32'(ci);
            co  = ({1'b0, x} >= ({1'b0, y} + 33'(ci)));
            r   = sx - sy - longint'(ci);
        end
        ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        return {ov, co, res};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic single_op(input string tag,
                             input logic [31:0] x,
                             input logic [31:0] y,
                             input logic ci,
                             input logic s,
                             input logic [33:0] exp);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a    = x;
        b    = y;
        c_in = ci;
        sub  = s;
        check({tag, "_rdy"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd4);
        check({tag, "_res"}, 64'({ovf, c_out, sum}), 64'(exp));
        step();
        check({tag, "_drain"}, 64'({out_valid, ovf, c_out, sum}), 64'd0);
    endtask

    task automatic run_stream(input string tag,
                              input int nops,
                              input int stall_lo,
                              input int stall_hi);
        int idx;
        idx       = 0;
        delivered = 0;
        first_del = -1;
        last_del  = -1;
        held      = 1'b0;
        for (int c = 1; c <= 60 && delivered < nops; c++) begin
            out_ready = !(c >= stall_lo && c <= stall_hi);
            in_valid  = (idx < nops);
            if (idx < nops) begin
                {a, b, c_in, sub} = ops[idx];
            end
            @(negedge clk);
            if (held) begin
                check({tag, "_hold"}, 64'({out_valid, ovf, c_out, sum}),
                      64'({1'b1, held_val}));
            end
            held = 1'b0;
            if (out_valid && !out_ready) begin
                check({tag, "_inrdy"}, 64'(in_ready), 64'd0);
                held     = 1'b1;
                held_val = {ovf, c_out, sum};
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_spur"}, 64'(out_valid), 64'd0);
                end else begin
                    check({tag, "_res"}, 64'({ovf, c_out, sum}),
                          64'(exp_q.pop_front()));
                    delivered++;
                    if (first_del < 0) first_del = c;
                    last_del = c;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, c_in, sub));
                idx++;
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_count"}, 64'(delivered), 64'(nops));
        check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [64:0] v;

        // Reset with random inputs presented.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a    = $urandom;
        b    = $urandom;
        c_in = 1'b1;
        sub  = 1'b0;
        repeat (3) step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'({ovf, c_out, sum}), 64'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();
        check("rst_inrdy", 64'(in_ready), 64'd1);
        check("rst_idle", 64'(out_valid), 64'd0);

        // Directed single operations.
        single_op("ripple", 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0,
                  {1'b0, 1'b1, 32'h00000000});
        single_op("subovf", 32'h80000000, 32'h1, 1'b0, 1'b1,
                  {1'b1, 1'b1, 32'h7FFFFFFF});
        single_op("subneg", 32'h5, 32'h7, 1'b0, 1'b1,
                  {1'b0, 1'b0, 32'hFFFFFFFE});
        single_op("addovf", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0,
                  {1'b1, 1'b0, 32'h80000000});
        single_op("subbin", 32'h0, 32'h0, 1'b1, 1'b1,
                  {1'b0, 1'b0, 32'hFFFFFFFF});

        // Streaming with incrementing {c_in, a, b}.
        for (int i = 0; i < 8; i++) begin
            v = {1'b0, 32'h7FFFFFFF, 32'hFFFFFFFC} + 65'(i);
            ops[i] = {v[63:32], v[31:0], v[64], 1'(i % 2)};
        end
        run_stream("stream", 8, 0, 0);
        check("stream_first", 64'(first_del), 64'd5);
        check("stream_rate", 64'(last_del - first_del), 64'd7);

        // Backpressure: 6 ops, downstream stalls in cycles 5-8.
        ops[0] = {32'h00000010, 32'h00000020, 1'b0, 1'b0};
        ops[1] = {32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0};
        ops[2] = {32'h80000000, 32'h80000000, 1'b0, 1'b0};
        ops[3] = {32'h12345678, 32'h12345678, 1'b1, 1'b1};
        ops[4] = {32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1};
        ops[5] = {32'hDEADBEEF, 32'h01234567, 1'b1, 1'b0};
        run_stream("bp", 6, 5, 8);

        // Reset with three operations in flight.
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a    = 32'h100 + 32'(i);
            b    = 32'h3;
            c_in = 1'b0;
            sub  = 1'b0;
            step();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_async", 64'(out_valid), 64'd0);
        repeat (2) begin
            @(negedge clk);
            check("midrst_hold", 64'({out_valid, ovf, c_out, sum}), 64'd0);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst_stale", 64'(out_valid), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
